// File: rtl/seg7_pkg.sv
// Shared constants and types for the adder / seven-segment display block.
package seg7_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_ACC = 2'b01;
  localparam logic [1:0] OP_CLR = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  // Active-low segments g..a on bits 6..0; all ones is a dark digit.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } disp_state_e;

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment decoder (g..a on bits 6..0).
module hex_to_seg (
  input  logic [3:0] nibble,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = 7'h7F;
    case (nibble)
      4'h0: seg_c = 7'b1000000;
      4'h1: seg_c = 7'b1111001;
      4'h2: seg_c = 7'b0100100;
      4'h3: seg_c = 7'b0110000;
      4'h4: seg_c = 7'b0011001;
      4'h5: seg_c = 7'b0010010;
      4'h6: seg_c = 7'b0000010;
      4'h7: seg_c = 7'b1111000;
      4'h8: seg_c = 7'b0000000;
      4'h9: seg_c = 7'b0010000;
      4'hA: seg_c = 7'b0001000;
      4'hB: seg_c = 7'b0000011;
      4'hC: seg_c = 7'b1000110;
      4'hD: seg_c = 7'b0100001;
      4'hE: seg_c = 7'b0000110;
      4'hF: seg_c = 7'b0001110;
      default: seg_c = 7'h7F;
    endcase
  end

endmodule

// File: rtl/adder_display_mux.sv
// Add/accumulate unit whose result is shown as hex on a multiplexed
// seven-segment display with per-slot anode blanking.
module adder_display_mux
  import seg7_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned BLANK_LZ     = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  input  logic [1:0]            op,
  input  logic                  load,
  output logic                  done,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  ovf
);

  localparam int unsigned DW   = 4 * NUM_DIGITS;
  localparam int unsigned CNTW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNTW-1:0] CNT_LAST  = CNTW'(REFRESH_DIV - 1);
  localparam logic [CNTW-1:0] BLANK_END = CNTW'(BLANK_CYCLES);
  localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(NUM_DIGITS - 1);

  logic [WIDTH-1:0]      result_q, result_d;
  logic                  ovf_q, ovf_d;
  logic                  done_q, done_d;
  logic [WIDTH:0]        add_sum_c, acc_sum_c;

  logic [CNTW-1:0]       cnt_q, cnt_d;
  logic [IDXW-1:0]       idx_q, idx_d;
  disp_state_e           state_q, state_d;
  logic [DW-1:0]         disp_q, disp_d;
  logic [DW-1:0]         disp_shift_c;
  logic [3:0]            nibble_c;
  logic [6:0]            hex_seg_c;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  assign add_sum_c = {1'b0, a} + {1'b0, b};
  assign acc_sum_c = {1'b0, result_q} + {1'b0, a};

  // Arithmetic: ACC keeps overflow sticky; reserved op is a silent no-op.
  always_comb begin
    result_d = result_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    if (load) begin
      case (op)
        OP_ADD: begin
          result_d = add_sum_c[WIDTH-1:0];
          ovf_d    = add_sum_c[WIDTH];
        end
        OP_ACC: begin
          result_d = acc_sum_c[WIDTH-1:0];
          ovf_d    = ovf_q | acc_sum_c[WIDTH];
        end
        OP_CLR: begin
          result_d = '0;
          ovf_d    = 1'b0;
        end
        default: ;
      endcase
      done_d = (op != OP_NOP);
    end
  end

  // Slot timing and next display state; the value is latched at slot start.
  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    state_d = state_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    state_d      = (cnt_d < BLANK_END) ? ST_BLANK : ST_SHOW;
    disp_d       = (cnt_d == '0) ? DW'(result_q) : disp_q;
    disp_shift_c = disp_d >> {idx_d, 2'b00};
    nibble_c     = disp_shift_c[3:0];
  end

  hex_to_seg u_hex_to_seg (
    .nibble (nibble_c),
    .seg_c  (hex_seg_c)
  );

  // Anode/segment drive for the upcoming cycle, including leading-zero blanking.
  always_comb begin
    an_d  = '1;
    seg_d = SEG_BLANK;
    if (state_d == ST_SHOW) begin
      an_d = ~(NUM_DIGITS'(1) << idx_d);
      if (!((BLANK_LZ != 0) && (idx_d != '0) && (disp_shift_c == '0))) begin
        seg_d = hex_seg_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      idx_q    <= '0;
      state_q  <= ST_BLANK;
      disp_q   <= '0;
      seg_q    <= SEG_BLANK;
      an_q     <= '1;
    end else begin
      result_q <= result_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      state_q  <= state_d;
      disp_q   <= disp_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  assign done = done_q;
  assign ovf  = ovf_q;
  assign seg  = seg_q;
  assign an   = an_q;

endmodule

// File: tb/tb_adder_display_mux.sv
// Directed bench for adder_display_mux: arithmetic, done/ovf, refresh walk,
// leading-zero blanking and reset override.
module tb_adder_display_mux;

  localparam int unsigned W  = 8;
  localparam int unsigned ND = 4;
  localparam int unsigned RD = 4;
  localparam int unsigned BC = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  a, b;
  logic [1:0]    op;
  logic          load;

  logic          done, ovf, done_lz, ovf_lz;
  logic [6:0]    seg, seg_lz;
  logic [ND-1:0] an, an_lz;

  int n_tests = 0;
  int n_fail  = 0;

  int m_cnt;
  int m_idx;

  always #5 clk = ~clk;

  adder_display_mux #(
    .WIDTH(W), .NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC), .BLANK_LZ(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .op(op), .load(load),
    .done(done), .seg(seg), .an(an), .ovf(ovf)
  );

  adder_display_mux #(
    .WIDTH(W), .NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC), .BLANK_LZ(1)
  ) dut_lz (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .op(op), .load(load),
    .done(done_lz), .seg(seg_lz), .an(an_lz), .ovf(ovf_lz)
  );

  // Reference slot position: counter and digit index as seen after each edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0;
      m_idx <= 0;
    end else if (m_cnt == RD - 1) begin
      m_cnt <= 0;
      m_idx <= (m_idx + 1) % ND;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg,
                            input logic e_ovf, input logic e_done);
    check({tag, " an"}, 32'(an), 32'(e_an));
    check({tag, " seg"}, 32'(seg), 32'(e_seg));
    check({tag, " ovf"}, 32'(ovf), 32'(e_ovf));
    check({tag, " done"}, 32'(done), 32'(e_done));
    check({tag, " an_lz"}, 32'(an_lz), 32'(e_an));
    check({tag, " seg_lz"}, 32'(seg_lz), 32'(e_seg));
  endtask

  // Waits for a fresh slot start, then checks four full slots.
  // Expected digits are packed {d3,d2,d1,d0}, 7 bits each.
  task automatic check_display(input string tag, input logic [27:0] e0, input logic [27:0] e1);
    logic [3:0] exp_an;
    @(negedge clk);
    for (int k = 0; k < 2 * RD && m_cnt != 0; k++) @(negedge clk);
    check({tag, " slot align"}, 32'(m_cnt), 32'd0);
    for (int i = 0; i < ND * RD; i++) begin
      if (m_cnt < BC) begin
        check($sformatf("%s blank an c%0d", tag, i), 32'(an), 32'hF);
        check($sformatf("%s blank seg c%0d", tag, i), 32'(seg), 32'h7F);
        check($sformatf("%s blank an_lz c%0d", tag, i), 32'(an_lz), 32'hF);
        check($sformatf("%s blank seg_lz c%0d", tag, i), 32'(seg_lz), 32'h7F);
      end else begin
        exp_an = ~(4'(1) << m_idx);
        check($sformatf("%s an d%0d", tag, m_idx), 32'(an), 32'(exp_an));
        check($sformatf("%s seg d%0d", tag, m_idx), 32'(seg), 32'(e0[m_idx*7 +: 7]));
        check($sformatf("%s an_lz d%0d", tag, m_idx), 32'(an_lz), 32'(exp_an));
        check($sformatf("%s seg_lz d%0d", tag, m_idx), 32'(seg_lz), 32'(e1[m_idx*7 +: 7]));
      end
      @(negedge clk);
    end
  endtask

  // Single-cycle load strobe issued on a falling edge.
  task automatic do_load(input string tag, input logic [1:0] o, input logic [7:0] av,
                         input logic [7:0] bv, input logic e_done, input logic e_ovf);
    op = o; a = av; b = bv; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check({tag, " done"}, 32'(done), 32'(e_done));
    check({tag, " ovf"}, 32'(ovf), 32'(e_ovf));
    check({tag, " ovf_lz"}, 32'(ovf_lz), 32'(e_ovf));
    @(negedge clk);
    check({tag, " done off"}, 32'(done), 32'd0);
  endtask

  localparam logic [27:0] D_00   = {7'h40, 7'h40, 7'h40, 7'h40};
  localparam logic [27:0] L_00   = {7'h7F, 7'h7F, 7'h7F, 7'h40};
  localparam logic [27:0] D_41   = {7'h40, 7'h40, 7'h19, 7'h79};
  localparam logic [27:0] L_41   = {7'h7F, 7'h7F, 7'h19, 7'h79};
  localparam logic [27:0] D_01   = {7'h40, 7'h40, 7'h40, 7'h79};
  localparam logic [27:0] L_01   = {7'h7F, 7'h7F, 7'h7F, 7'h79};
  localparam logic [27:0] D_02   = {7'h40, 7'h40, 7'h40, 7'h24};
  localparam logic [27:0] L_02   = {7'h7F, 7'h7F, 7'h7F, 7'h24};
  localparam logic [27:0] D_0A   = {7'h40, 7'h40, 7'h40, 7'h08};
  localparam logic [27:0] L_0A   = {7'h7F, 7'h7F, 7'h7F, 7'h08};
  localparam logic [27:0] D_F0   = {7'h40, 7'h40, 7'h0E, 7'h40};
  localparam logic [27:0] L_F0   = {7'h7F, 7'h7F, 7'h0E, 7'h40};
  localparam logic [27:0] D_ED   = {7'h40, 7'h40, 7'h06, 7'h21};
  localparam logic [27:0] L_ED   = {7'h7F, 7'h7F, 7'h06, 7'h21};
  localparam logic [27:0] D_65   = {7'h40, 7'h40, 7'h02, 7'h12};
  localparam logic [27:0] L_65   = {7'h7F, 7'h7F, 7'h02, 7'h12};

  initial begin
    logic [27:0] old_digits;
    rst_n = 1'b0; load = 1'b0; a = '0; b = '0; op = 2'b00;
    repeat (2) @(negedge clk);
    check_outs("reset", 4'hF, 7'h7F, 1'b0, 1'b0);
    rst_n = 1'b1;

    check_display("idle", D_00, L_00);
    check("idle ovf", 32'(ovf), 32'd0);
    check("idle done", 32'(done), 32'd0);

    do_load("add 3c+05", 2'b00, 8'h3C, 8'h05, 1'b1, 1'b0);
    check_display("val 41", D_41, L_41);

    // Load in the middle of a SHOW slot: current slot keeps the old value.
    for (int k = 0; k < 2 * RD && m_cnt != 1; k++) @(negedge clk);
    old_digits = D_41;
    do_load("add ff+02", 2'b00, 8'hFF, 8'h02, 1'b1, 1'b1);
    check("midslot seg", 32'(seg), 32'(old_digits[m_idx*7 +: 7]));
    check_display("val 01", D_01, L_01);

    do_load("add 01+01", 2'b00, 8'h01, 8'h01, 1'b1, 1'b0);
    check_display("val 02", D_02, L_02);

    do_load("clr", 2'b10, 8'h00, 8'h00, 1'b1, 1'b0);
    do_load("acc 80 #1", 2'b01, 8'h80, 8'h00, 1'b1, 1'b0);
    do_load("acc 80 #2", 2'b01, 8'h80, 8'h00, 1'b1, 1'b1);
    check_display("acc 00", D_00, L_00);
    do_load("acc 01", 2'b01, 8'h01, 8'h00, 1'b1, 1'b1);
    check_display("acc 01", D_01, L_01);

    do_load("op11", 2'b11, 8'h55, 8'h55, 1'b0, 1'b1);
    check_display("op11 hold", D_01, L_01);
    do_load("clr2", 2'b10, 8'h00, 8'h00, 1'b1, 1'b0);

    // Back-to-back loads give back-to-back done pulses.
    op = 2'b00; a = 8'h3C; b = 8'h05; load = 1'b1;
    @(negedge clk);
    check("b2b done 1", 32'(done), 32'd1);
    a = 8'h01; b = 8'h01;
    @(negedge clk);
    check("b2b done 2", 32'(done), 32'd1);
    load = 1'b0;
    @(negedge clk);
    check("b2b done off", 32'(done), 32'd0);
    check_display("b2b val 02", D_02, L_02);

    do_load("add 05+05", 2'b00, 8'h05, 8'h05, 1'b1, 1'b0);
    check_display("val 0a", D_0A, L_0A);
    do_load("add f0+00", 2'b00, 8'hF0, 8'h00, 1'b1, 1'b0);
    check_display("val f0", D_F0, L_F0);
    do_load("add c0+2d", 2'b00, 8'hC0, 8'h2D, 1'b1, 1'b0);
    check_display("val ed", D_ED, L_ED);
    do_load("add 36+2f", 2'b00, 8'h36, 8'h2F, 1'b1, 1'b0);
    check_display("val 65", D_65, L_65);

    // Reset asserted mid-SHOW together with a load.
    do_load("add ff+02 b", 2'b00, 8'hFF, 8'h02, 1'b1, 1'b1);
    for (int k = 0; k < 2 * RD && m_cnt != 2; k++) @(negedge clk);
    op = 2'b00; a = 8'h01; b = 8'h01; load = 1'b1;
    rst_n = 1'b0;
    #1;
    check_outs("rst async", 4'hF, 7'h7F, 1'b0, 1'b0);
    @(negedge clk);
    check_outs("rst held", 4'hF, 7'h7F, 1'b0, 1'b0);
    load = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("post rst an", 32'(an), 32'hE);
    check("post rst seg", 32'(seg), 32'h40);
    check("post rst done", 32'(done), 32'd0);
    check_display("post rst", D_00, L_00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
